// File: rtl/btn_toggle_pulse.sv
// Push-button front end: two-flop synchroniser, stability-counter debounce and a
// press/hold/repeat FSM that issues single-cycle toggle pulses on t.
module btn_toggle_pulse #(
  parameter int DEBOUNCE  = 16,
  parameter int HOLD      = 64,
  parameter int REPEAT    = 32,
  parameter int REPEAT_EN = 1,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  output logic       t,
  output logic       level,
  output logic       rep,
  output logic [1:0] fsm_state
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam bit               REP_ON    = (REPEAT_EN != 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRESSED = 2'd1,
    S_REPEAT  = 2'd2
  } state_t;

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] dcnt;
  logic             differ;
  logic             deb_done;
  logic             rise;
  logic             fall;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] hcnt_n;
  logic             t_n;
  logic             rep_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
    end
  end

  // level only follows s2 after DEBOUNCE consecutive differing cycles
  assign differ   = (s2 != level);
  assign deb_done = differ && (dcnt == DEB_LAST);
  assign rise     = deb_done && s2;
  assign fall     = deb_done && !s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dcnt  <= '0;
      level <= 1'b0;
    end else if (!differ) begin
      dcnt <= '0;
    end else if (deb_done) begin
      dcnt  <= '0;
      level <= s2;
    end else begin
      dcnt <= dcnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      hcnt  <= '0;
      t     <= 1'b0;
      rep   <= 1'b0;
    end else begin
      state <= state_n;
      hcnt  <= hcnt_n;
      t     <= t_n;
      rep   <= rep_n;
    end
  end

  // Events are taken from the debounce next-state so t rises on the same edge as level
  always_comb begin
    state_n = state;
    hcnt_n  = hcnt;
    t_n     = 1'b0;
    rep_n   = rep;
    if (fall) begin
      state_n = S_IDLE;
      hcnt_n  = '0;
      rep_n   = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rise) begin
            t_n     = 1'b1;
            hcnt_n  = '0;
            state_n = S_PRESSED;
          end
        end
        S_PRESSED: begin
          if (REP_ON && (hcnt == HOLD_LAST)) begin
            t_n     = 1'b1;
            hcnt_n  = '0;
            rep_n   = 1'b1;
            state_n = S_REPEAT;
          end else if (hcnt != HOLD_LAST) begin
            hcnt_n = hcnt + CNT_ONE;
          end
        end
        S_REPEAT: begin
          if (hcnt == REP_LAST) begin
            t_n    = 1'b1;
            hcnt_n = '0;
          end else begin
            hcnt_n = hcnt + CNT_ONE;
          end
        end
        default: begin
          state_n = S_IDLE;
          hcnt_n  = '0;
          rep_n   = 1'b0;
        end
      endcase
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_btn_toggle_pulse.sv
// Directed bench for btn_toggle_pulse with DEBOUNCE=4, HOLD=10, REPEAT=3; a second
// instance with auto-repeat disabled feeds a model of the downstream toggle flop.
module tb_btn_toggle_pulse;

  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn = 1'b0;
  logic       t, level, rep;
  logic       t_nr, level_nr, rep_nr;
  logic [1:0] st, st_nr;
  logic       q;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  btn_toggle_pulse #(
    .DEBOUNCE(DEB), .HOLD(HOLD), .REPEAT(REP), .REPEAT_EN(1), .CNT_W(16)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn),
    .t(t), .level(level), .rep(rep), .fsm_state(st)
  );

  btn_toggle_pulse #(
    .DEBOUNCE(DEB), .HOLD(HOLD), .REPEAT(REP), .REPEAT_EN(0), .CNT_W(16)
  ) dut_nr (
    .clk(clk), .rst(rst), .btn(btn),
    .t(t_nr), .level(level_nr), .rep(rep_nr), .fsm_state(st_nr)
  );

  // Downstream toggle flip-flop driven by the single-pulse instance
  always @(posedge clk or negedge rst) begin
    if (!rst) q <= 1'b0;
    else if (t_nr) q <= ~q;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    btn = 1'b0;
    repeat (3) step();
    checks++; if (t !== 1'b0) begin failures++; $display("FAIL reset_t got=%b want=0", t); end
    checks++; if (level !== 1'b0) begin failures++; $display("FAIL reset_level got=%b want=0", level); end
    checks++; if (rep !== 1'b0) begin failures++; $display("FAIL reset_rep got=%b want=0", rep); end
    checks++; if (st !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d want=0", st); end
    rst = 1'b1;
    repeat (8) step();
    checks++; if (level !== 1'b0 || t !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset level=%b t=%b want=0,0", level, t);
    end
  endtask

  // Press held through two repeats; released after edge 19, so level falls at edge 25
  task automatic test_clean_press();
    logic exp_t, exp_level, exp_rep;
    btn = 1'b1;
    for (int e = 0; e <= 40; e++) begin
      step();
      exp_level = (e >= 5 && e <= 24);
      exp_rep   = (e >= 15 && e <= 24);
      exp_t     = (e == 5) || (e >= 15 && e <= 24 && ((e - 15) % 3 == 0));
      checks++; if (t !== exp_t) begin failures++; $display("FAIL press_t edge=%0d got=%b want=%b", e, t, exp_t); end
      checks++; if (level !== exp_level) begin failures++; $display("FAIL press_level edge=%0d got=%b want=%b", e, level, exp_level); end
      checks++; if (rep !== exp_rep) begin failures++; $display("FAIL press_rep edge=%0d got=%b want=%b", e, rep, exp_rep); end
      if (e == 6) begin
        checks++; if (st !== 2'd1) begin failures++; $display("FAIL press_state edge=6 got=%0d want=1", st); end
      end
      if (e == 15) begin
        checks++; if (st !== 2'd2) begin failures++; $display("FAIL repeat_state edge=15 got=%0d want=2", st); end
      end
      if (e == 25) begin
        checks++; if (st !== 2'd0) begin failures++; $display("FAIL release_state edge=25 got=%0d want=0", st); end
      end
      if (e == 19) btn = 1'b0;
    end
  endtask

  task automatic test_bounce();
    int widths [10];
    widths = '{2, 1, 3, 1, 2, 3, 1, 2, 2, 3};
    for (int i = 0; i < 10; i++) begin
      btn = (i % 2 == 0);
      for (int w = 0; w < widths[i]; w++) begin
        step();
        checks++; if (t !== 1'b0 || level !== 1'b0) begin
          failures++; $display("FAIL bounce_quiet run=%0d t=%b level=%b want=0,0", i, t, level);
        end
      end
    end
    btn = 1'b1;
    for (int e = 0; e <= 12; e++) begin
      step();
      checks++; if (t !== (e == 5)) begin failures++; $display("FAIL bounce_t edge=%0d got=%b want=%b", e, t, (e == 5)); end
      checks++; if (level !== (e >= 5)) begin failures++; $display("FAIL bounce_level edge=%0d got=%b want=%b", e, level, (e >= 5)); end
    end
    btn = 1'b0;
    repeat (12) step();
    checks++; if (level !== 1'b0 || rep !== 1'b0) begin
      failures++; $display("FAIL bounce_release level=%b rep=%b want=0,0", level, rep);
    end
  endtask

  task automatic test_no_repeat();
    int pulses = 0;
    int first  = -1;
    bit rep_seen  = 1'b0;
    bit level_bad = 1'b0;
    btn = 1'b1;
    for (int e = 0; e < 200; e++) begin
      step();
      if (t_nr) begin
        pulses++;
        if (first < 0) first = e;
      end
      if (rep_nr) rep_seen = 1'b1;
      if (level_nr !== (e >= 5)) level_bad = 1'b1;
    end
    checks++; if (pulses != 1) begin failures++; $display("FAIL norep_pulses got=%0d want=1", pulses); end
    checks++; if (first != 5) begin failures++; $display("FAIL norep_first_edge got=%0d want=5", first); end
    checks++; if (rep_seen) begin failures++; $display("FAIL norep_rep got=1 want=0"); end
    checks++; if (level_bad) begin failures++; $display("FAIL norep_level got=unstable want=1 from edge 5"); end
    checks++; if (st_nr !== 2'd1) begin failures++; $display("FAIL norep_state got=%0d want=1", st_nr); end
    btn = 1'b0;
    repeat (12) step();
    checks++; if (level_nr !== 1'b0) begin failures++; $display("FAIL norep_release got=%b want=0", level_nr); end
  endtask

  task automatic test_async_reset();
    btn = 1'b1;
    for (int e = 0; e <= 15; e++) step();
    checks++; if (t !== 1'b1 || rep !== 1'b1 || level !== 1'b1) begin
      failures++; $display("FAIL areset_pre t=%b rep=%b level=%b want=1,1,1", t, rep, level);
    end
    #2 rst = 1'b0;
    #1;
    checks++; if (t !== 1'b0 || level !== 1'b0 || rep !== 1'b0) begin
      failures++; $display("FAIL areset_immediate t=%b level=%b rep=%b want=0,0,0", t, level, rep);
    end
    checks++; if (st !== 2'd0 || level_nr !== 1'b0) begin
      failures++; $display("FAIL areset_state st=%0d level_nr=%b want=0,0", st, level_nr);
    end
    repeat (2) step();
    rst = 1'b1;
    for (int e = 0; e <= 10; e++) begin
      step();
      checks++; if (t !== (e == 5)) begin failures++; $display("FAIL areset_t edge=%0d got=%b want=%b", e, t, (e == 5)); end
      checks++; if (level !== (e >= 5)) begin failures++; $display("FAIL areset_level edge=%0d got=%b want=%b", e, level, (e >= 5)); end
    end
    btn = 1'b0;
    repeat (12) step();
  endtask

  task automatic test_chain();
    logic exp_seq [3];
    logic q_prev;
    int   toggles;
    exp_seq = '{1'b1, 1'b0, 1'b1};
    btn = 1'b0;
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    checks++; if (q !== 1'b0) begin failures++; $display("FAIL chain_start got=%b want=0", q); end
    for (int p = 0; p < 3; p++) begin
      toggles = 0;
      q_prev  = q;
      btn     = 1'b1;
      for (int c = 0; c < 24; c++) begin
        if (c == 12) btn = 1'b0;
        step();
        if (q !== q_prev) toggles++;
        q_prev = q;
      end
      checks++; if (q !== exp_seq[p]) begin failures++; $display("FAIL chain_q press=%0d got=%b want=%b", p, q, exp_seq[p]); end
      checks++; if (toggles != 1) begin failures++; $display("FAIL chain_toggles press=%0d got=%0d want=1", p, toggles); end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_no_repeat();
    test_async_reset();
    test_chain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
